rf_sequencer: RTL and testbench

Multi-cycle instruction sequencer that sits directly upstream of the 16-entry register file. It accepts one 16-bit instruction per handshake and drives the register file's read selects (`rs1`, `rs2`), write select (`rs3`), write enable and write data. It reads the two operands back, executes one ALU operation and writes the result back. The block is the control/execute stage of the lab datapath and keeps a 4-bit condition-flag register.

---
 rtl/rf_seq_pkg.sv | 36 +++
 rtl/rf_sequencer_alu_core.sv | 85 ++++++++
 rtl/rf_sequencer.sv | 126 ++++++++++++
 tb/tb_rf_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_seq_pkg.sv
// Shared opcode, FSM-state, instruction-field and flag-index definitions for rf_sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rf_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_ORR = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LSL = 4'h6;
    localparam logic [3:0] OP_LSR = 4'h7;
    localparam logic [3:0] OP_MOV = 4'h8;
    localparam logic [3:0] OP_LDI = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int FLD_W   = 4;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 8;
    localparam int RA_LSB  = 4;
    localparam int RB_LSB  = 0;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/rf_sequencer_alu_core.sv
// Combinational ALU: result, next {N,Z,C,V}, write-enable and illegal decode for one opcode.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
module alu_core
    import rf_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   cur_flags,
    output logic [W-1:0] result,
    output logic [3:0]   next_flags,
    output logic         writes_rd,
    output logic         is_illegal
);

    logic [W:0] sum;
    logic [W:0] diff;
    logic       add_v;
    logic       sub_v;
    logic       arith;
    logic       nz_upd;
    logic       carry;
    logic       ovf;

    // Subtraction as A + ~B + 1 so bit W is the no-borrow carry.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign add_v = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    assign sub_v = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);

    always_comb begin
        result     = '0;
        next_flags = cur_flags;
        writes_rd  = 1'b1;
        is_illegal = 1'b0;
        arith      = 1'b0;
        nz_upd     = 1'b1;
        carry      = 1'b0;
        ovf        = 1'b0;
        case (op)
            OP_NOP: begin
                writes_rd = 1'b0;
                nz_upd    = 1'b0;
            end
            OP_ADD: begin
                result = sum[W-1:0];
                arith  = 1'b1;
                carry  = sum[W];
                ovf    = add_v;
            end
            OP_SUB, OP_CMP: begin
                result    = diff[W-1:0];
                arith     = 1'b1;
                carry     = diff[W];
                ovf       = sub_v;
                writes_rd = (op == OP_SUB);
            end
            OP_AND: result = a & b;
            OP_ORR: result = a | b;
            OP_XOR: result = a ^ b;
            // Shift by the full B value; amounts >= W naturally give zero.
            OP_LSL: result = a << b;
            OP_LSR: result = a >> b;
            OP_MOV: result = a;
            OP_LDI: result = b;
            default: begin
                writes_rd  = 1'b0;
                is_illegal = 1'b1;
                nz_upd     = 1'b0;
            end
        endcase
        if (nz_upd) begin
            next_flags[FLAG_N] = result[W-1];
            next_flags[FLAG_Z] = (result == '0);
        end
        if (arith) begin
            next_flags[FLAG_C] = carry;
            next_flags[FLAG_V] = ovf;
        end
    end

endmodule

// File: rtl/rf_sequencer.sv
// Control/execute sequencer: reads two registers, runs one ALU op, writes the result back.
// Latency: fixed 4 cycles per instruction (accept, READ, EXEC, WRITE with done).
// Backpressure: instr_ready is high only in IDLE; instr/instr_valid are ignored otherwise.
module rf_sequencer
    import rf_seq_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [15:0]  instr,
    input  logic         instr_valid,
    output logic         instr_ready,
    output logic [3:0]   rs1,
    output logic [3:0]   rs2,
    output logic [3:0]   rs3,
    output logic         we,
    output logic [W-1:0] wdata,
    input  logic [W-1:0] rdata1,
    input  logic [W-1:0] rdata2,
    output logic [3:0]   flags,
    output logic         done,
    output logic         illegal
);

    state_t       state;
    state_t       state_nxt;
    logic [15:0]  ir;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] res_q;
    logic [3:0]   flags_q;
    logic [W-1:0] imm_ext;
    logic [3:0]   op;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         alu_writes;
    logic         alu_illegal;

    assign op  = ir[OPC_LSB +: FLD_W];
    assign rs1 = ir[RA_LSB  +: FLD_W];
    assign rs2 = ir[RB_LSB  +: FLD_W];
    assign rs3 = ir[RD_LSB  +: FLD_W];

    assign wdata = res_q;
    assign flags = flags_q;

    always_comb begin
        imm_ext      = '0;
        imm_ext[7:0] = ir[7:0];
    end

    alu_core #(.W(W)) u_alu (
        .op         (op),
        .a          (op_a),
        .b          (op_b),
        .cur_flags  (flags_q),
        .result     (alu_result),
        .next_flags (alu_flags),
        .writes_rd  (alu_writes),
        .is_illegal (alu_illegal)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Op decode is stable from the instruction register, so WRITE outputs stay Moore.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        done        = 1'b0;
        we          = 1'b0;
        illegal     = 1'b0;
        case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ:  state_nxt = ST_EXEC;
            ST_EXEC:  state_nxt = ST_WRITE;
            ST_WRITE: begin
                state_nxt = ST_IDLE;
                done      = 1'b1;
                we        = alu_writes;
                illegal   = alu_illegal;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            ir      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                ST_READ: begin
                    op_a <= rdata1;
                    // LDI carries its immediate through the B operand path.
                    op_b <= (op == OP_LDI) ? imm_ext : rdata2;
                end
                ST_EXEC: begin
                    res_q   <= alu_result;
                    flags_q <= alu_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: behavioural register file + transaction model, per-cycle compare,
// directed literal scenarios and a randomized instruction stream.
module tb_rf_sequencer;

    localparam int W = 32;
    localparam longint U32MAX = 64'h0000_0000_FFFF_FFFF;
    localparam longint SMAX   = 64'sd2147483647;
    localparam longint SMIN   = -64'sd2147483648;

    logic         clock = 1'b0;
    logic         reset;
    logic [15:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [3:0]   rs1, rs2, rs3;
    logic         we;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata1, rdata2;
    logic [3:0]   flags;
    logic         done;
    logic         illegal;

    always #5 clock = ~clock;

    rf_sequencer #(.W(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs3         (rs3),
        .we          (we),
        .wdata       (wdata),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .flags       (flags),
        .done        (done),
        .illegal     (illegal)
    );

    // Register file seen by the DUT, plus a preload port for the bench.
    logic [W-1:0] rf  [16] = '{default: '0};
    logic [W-1:0] mrf [16] = '{default: '0};
    logic         pre_en  = 1'b0;
    logic [3:0]   pre_idx = '0;
    logic [W-1:0] pre_val = '0;

    assign rdata1 = rf[rs1];
    assign rdata2 = rf[rs2];

    always @(posedge clock) begin
        if (we) rf[rs3] <= wdata;
        else if (pre_en) rf[pre_idx] <= pre_val;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       input logic [7:0] imm, input logic [3:0] fl,
                                       output logic [31:0] r, output logic [3:0] nf,
                                       output logic wr, output logic ill);
        longint sa, sb, s;
        logic c, v;
        sa = $signed(a);
        sb = $signed(b);
        s = 0; c = 1'b0; r = '0; nf = fl;
        wr  = (op >= 4'd1) && (op <= 4'd9);
        ill = (op > 4'd10);
        case (op)
            4'd1: begin r = a + b; c = (longint'(a) + longint'(b)) > U32MAX; s = sa + sb; end
            4'd2, 4'd10: begin r = a - b; c = (a >= b); s = sa - sb; end
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd6: r = (b >= 32) ? 32'd0 : (a << b[4:0]);
            4'd7: r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            4'd8: r = a;
            4'd9: r = {24'd0, imm};
            default: r = '0;
        endcase
        v = (s > SMAX) || (s < SMIN);
        if (op == 4'd1 || op == 4'd2 || op == 4'd10) nf = {r[31], r == 0, c, v};
        else if (wr) nf = {r[31], r == 0, fl[1:0]};
    endfunction

    // Transaction model: cnt counts cycles since acceptance (0 = idle).
    int          cnt = 0;
    bit          started = 1'b0;
    logic [15:0] last = '0;
    logic [3:0]  mflags = '0;
    logic [3:0]  xflags = '0;
    logic [31:0] xres = '0;
    logic        xwe = 1'b0;
    logic        xill = 1'b0;

    always @(posedge clock) begin
        if (pre_en) mrf[pre_idx] = pre_val;
        if (reset !== 1'b1) begin
            started = 1'b1;
            cnt = 0;
            mflags = '0;
            last = '0;
        end else if (started) begin
            if (cnt == 3) begin
                if (xwe) mrf[last[11:8]] = xres;
                cnt = 0;
            end else if (cnt != 0) begin
                if (cnt == 2) mflags = xflags;
                cnt++;
            end else if (instr_valid) begin
                last = instr;
                model_exec(instr[15:12], mrf[instr[7:4]], mrf[instr[3:0]], instr[7:0], mflags,
                           xres, xflags, xwe, xill);
                cnt = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (started && reset === 1'b1) begin
            chk("ready", instr_ready, cnt == 0);
            chk("done", done, cnt == 3);
            chk("we", we, (cnt == 3) && xwe);
            chk("illegal", illegal, (cnt == 3) && xill);
            chk("flags", flags, mflags);
            chk("rs1", rs1, last[7:4]);
            chk("rs2", rs2, last[3:0]);
            chk("rs3", rs3, last[11:8]);
            if (cnt == 3 && xwe) chk("wdata", wdata, xres);
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [W-1:0] val);
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clock);
        #1 pre_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("idle_wait", instr_ready, 1'b1);
    endtask

    task automatic issue_chk(input string tag, input logic [15:0] ins, input logic [31:0] ew,
                             input logic [3:0] ef, input logic ewe, input logic eill);
        wait_idle();
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_we"}, we, ewe);
        chk({tag, "_illegal"}, illegal, eill);
        chk({tag, "_flags"}, flags, ef);
        if (ewe) begin
            chk({tag, "_wdata"}, wdata, ew);
            chk({tag, "_rs3"}, rs3, ins[11:8]);
        end
        @(negedge clock);
        chk({tag, "_ready_after"}, instr_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b0;
        instr = '0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_flags", flags, 4'b0000);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rs", {rs1, rs2, rs3}, 12'h000);
        reset = 1'b1;

        preload(4'd1, 32'd5);
        preload(4'd2, 32'd3);
        issue_chk("add", 16'h1312, 32'd8, 4'b0000, 1'b1, 1'b0);

        preload(4'd1, 32'h8000_0000);
        issue_chk("sub_self", 16'h2411, 32'd0, 4'b0110, 1'b1, 1'b0);
        preload(4'd8, 32'h7FFF_FFFF);
        issue_chk("add_ovf", 16'h1988, 32'hFFFF_FFFE, 4'b1001, 1'b1, 1'b0);

        issue_chk("ldi", 16'h95A7, 32'h0000_00A7, 4'b0001, 1'b1, 1'b0);
        preload(4'd7, 32'd4);
        issue_chk("lsl4", 16'h6657, 32'h0000_0A70, 4'b0001, 1'b1, 1'b0);
        preload(4'd7, 32'd40);
        issue_chk("lsl40", 16'h6657, 32'd0, 4'b0101, 1'b1, 1'b0);

        preload(4'd1, 32'd5);
        issue_chk("cmp", 16'hA012, 32'd0, 4'b0010, 1'b0, 1'b0);
        issue_chk("illegal_c", 16'hC000, 32'd0, 4'b0010, 1'b0, 1'b1);

        // Back-to-back with instr_valid held high.
        preload(4'd1, 32'd1);
        wait_idle();
        @(negedge clock);
        chk("b2b_ready0", instr_ready, 1'b1);
        instr = 16'h1111;
        instr_valid = 1'b1;
        for (int c = 1; c < 12; c++) begin
            @(negedge clock);
            chk("b2b_done", done, (c % 4) == 3);
            chk("b2b_ready", instr_ready, (c % 4) == 0);
            if (c == 9) instr_valid = 1'b0;
        end
        @(negedge clock);
        chk("b2b_r1", rf[1], 32'd8);

        // Reset during EXEC aborts the instruction.
        preload(4'd10, 32'hDEAD_0000);
        issue_chk("cmp2", 16'hA012, 32'd0, 4'b0010, 1'b0, 1'b0);
        wait_idle();
        @(negedge clock);
        instr = 16'h1A12;
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_flags", flags, 4'b0000);
        chk("abort_rs3", rs3, 4'd0);
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_done", {done, we}, 2'b00);
            @(negedge clock);
        end
        chk("abort_r10", rf[10], 32'hDEAD_0000);
        issue_chk("after_abort", 16'h1B12, 32'd11, 4'b0000, 1'b1, 1'b0);

        // Randomized stream against the model.
        for (int i = 0; i < 16; i++) preload(i[3:0], $urandom);
        @(negedge clock);
        for (int i = 0; i < 400; i++) begin
            instr_valid = $urandom_range(0, 1) == 1;
            instr = 16'($urandom);
            @(negedge clock);
        end
        instr_valid = 1'b0;
        repeat (6) @(negedge clock);
        for (int i = 0; i < 16; i++) chk("final_rf", rf[i], mrf[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
